// File: rtl/dm_access_ctrl_if.sv
// Core-side request/response bus of the data-memory access controller.
// master: the CPU core (issues requests, accepts responses).
// slave:  dm_access_ctrl (accepts requests, returns responses).
interface dm_access_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Initiator side of the data-memory (DM) interface.
// Takes one load/store at a time from the core, sequences memWrite/memRead
// towards the DM with address/data_in held stable, captures data_out and
// returns a response. Every output is registered.
// Optional feature macro: MEM_VERIFY_EN -- each store is followed by a
// read-back (VREAD) and rsp_err flags a mismatch. Without it rsp_err is 0.
module dm_access_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 1   // cycles memRead is held, 1..7
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_access_ctrl_if.slave   bus,
    output logic              memWrite,
    output logic              memRead,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    // Value of the read counter on the final memRead cycle.
    localparam logic [2:0] LAST = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP
`ifdef MEM_VERIFY_EN
        , VREAD
`endif
    } state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic              req_ready_n;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic              mem_write_n;
    logic              mem_read_n;
    logic [ADDR_W-1:0] address_n;
    logic [DATA_W-1:0] data_in_n;
`ifdef MEM_VERIFY_EN
    logic              rsp_err_n;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_ready_n = bus.req_ready;
        rsp_valid_n = bus.rsp_valid;
        rsp_rdata_n = bus.rsp_rdata;
        mem_write_n = memWrite;
        mem_read_n  = memRead;
        address_n   = address;
        data_in_n   = data_in;
`ifdef MEM_VERIFY_EN
        rsp_err_n   = bus.rsp_err;
`endif
        case (state)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    address_n   = bus.req_addr;
                    data_in_n   = bus.req_wdata;
                    req_ready_n = 1'b0;
                    cnt_n       = '0;
                    if (bus.req_we) begin
                        state_n     = WRITE;
                        mem_write_n = 1'b1;
                    end else begin
                        state_n    = READ;
                        mem_read_n = 1'b1;
                    end
                end
            end
            WRITE: begin
                // memWrite is a single-cycle strobe.
                mem_write_n = 1'b0;
`ifdef MEM_VERIFY_EN
                // Address is already set up, so the read-back starts at once.
                state_n     = VREAD;
                mem_read_n  = 1'b1;
                cnt_n       = '0;
`else
                state_n     = RESP;
                rsp_valid_n = 1'b1;
`endif
            end
            READ: begin
                if (cnt == LAST) begin
                    mem_read_n  = 1'b0;
                    rsp_rdata_n = data_out;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
`ifdef MEM_VERIFY_EN
            VREAD: begin
                if (cnt == LAST) begin
                    // rsp_rdata is left alone: stores keep the last load data.
                    mem_read_n  = 1'b0;
                    rsp_err_n   = (data_out != data_in);
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
`endif
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = IDLE;
`ifdef MEM_VERIFY_EN
                    rsp_err_n   = 1'b0;
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the DM strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            memWrite      <= 1'b0;
            memRead       <= 1'b0;
            address       <= '0;
            data_in       <= '0;
`ifdef MEM_VERIFY_EN
            bus.rsp_err   <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bus.req_ready <= req_ready_n;
            bus.rsp_valid <= rsp_valid_n;
            bus.rsp_rdata <= rsp_rdata_n;
            memWrite      <= mem_write_n;
            memRead       <= mem_read_n;
            address       <= address_n;
            data_in       <= data_in_n;
`ifdef MEM_VERIFY_EN
            bus.rsp_err   <= rsp_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Testbench for dm_access_ctrl: instance A (READ_LATENCY=1) runs directed and
// random traffic against a scoreboard; instance B (READ_LATENCY=3) covers the
// longer read latency and reset in the middle of a read.
module tb_dm_access_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int RL_A   = 1;
    localparam int RL_B   = 3;
`ifdef MEM_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    always #25 clk = ~clk;

    logic rst_n_a, rst_n_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dm_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
    dm_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

    logic              mw_a, mr_a, mw_b, mr_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] din_a, dout_a, din_b, dout_b;

    dm_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(RL_A)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .bus(bus_a),
        .memWrite(mw_a), .memRead(mr_a), .address(addr_a),
        .data_in(din_a), .data_out(dout_a)
    );

    dm_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(RL_B)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(bus_b),
        .memWrite(mw_b), .memRead(mr_b), .address(addr_b),
        .data_in(din_b), .data_out(dout_b)
    );

    // DM models: synchronous write, combinational read while memRead is high.
    logic [DATA_W-1:0] dm_a [32];
    logic [DATA_W-1:0] dm_b [32];
    logic              corrupt_a = 1'b0;
    always @(posedge clk) if (mw_a) dm_a[addr_a] <= din_a;
    always @(posedge clk) if (mw_b) dm_b[addr_b] <= din_b;
    assign dout_a = mr_a ? (dm_a[addr_a] ^ {7'b0, corrupt_a}) : '0;
    assign dout_b = mr_b ? dm_b[addr_b] : '0;

    // Reference model and scoreboard for instance A.
    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                lat;
        int                acc;
    } sb_entry_t;
    sb_entry_t         sbq[$];
    logic [DATA_W-1:0] ref_mem [32];
    logic [DATA_W-1:0] last_rd = '0;
    int                rdy_mode = 0;   // 0: ready, 1: random, 2: stalled

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request to A, wait (bounded) for its accept and record the expectation.
    task automatic issue_a(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sb_entry_t e;
        int n = 0;
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = we;
        bus_a.req_addr  = a;
        bus_a.req_wdata = d;
        @(negedge clk);
        while (!bus_a.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_a", {31'b0, bus_a.req_ready}, 32'd1);
        e.acc = cyc;
        if (we) begin
            ref_mem[a] = d;
            e.rdata    = last_rd;
            e.err      = VERIFY ? corrupt_a : 1'b0;
            e.lat      = VERIFY ? RL_A + 2 : 2;
        end else begin
            e.rdata = ref_mem[a];
            last_rd = ref_mem[a];
            e.err   = 1'b0;
            e.lat   = RL_A + 1;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        bus_a.req_we    = 1'($urandom);
        bus_a.req_addr  = ADDR_W'($urandom);
        bus_a.req_wdata = DATA_W'($urandom);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while ((sbq.size() != 0 || bus_a.rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_a", sbq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic issue_b(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           output int acc);
        int n = 0;
        bus_b.req_valid = 1'b1;
        bus_b.req_we    = we;
        bus_b.req_addr  = a;
        bus_b.req_wdata = d;
        @(negedge clk);
        while (!bus_b.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_b", {31'b0, bus_b.req_ready}, 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
    endtask

    task automatic wait_rsp_b(output int seen);
        int n = 0;
        @(negedge clk);
        while (!bus_b.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_b_seen", {31'b0, bus_b.rsp_valid}, 32'd1);
        seen = cyc;
    endtask

    // rsp_ready driver for A.
    initial begin
        bus_a.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus_a.rsp_ready = 1'b1;
                1:       bus_a.rsp_ready = 1'($urandom_range(0, 1));
                default: bus_a.rsp_ready = 1'b0;
            endcase
        end
    end

    // Response monitor for A: latency on the rising edge, data on the handshake.
    initial begin
        bit        prev = 1'b0;
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst_n_a) begin
                prev = 1'b0;
                continue;
            end
            if (bus_a.rsp_valid)
                chk("no_accept_while_rsp_a", {31'b0, bus_a.req_ready}, 32'd0);
            if (bus_a.rsp_valid && !prev) begin
                if (sbq.size() == 0)
                    chk("rsp_without_req_a", sbq.size(), 32'd1);
                else
                    chk("latency_a", cyc - sbq[0].acc, sbq[0].lat);
            end
            if (bus_a.rsp_valid && bus_a.rsp_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rsp_rdata_a", {24'b0, bus_a.rsp_rdata}, {24'b0, e.rdata});
                chk("rsp_err_a", {31'b0, bus_a.rsp_err}, {31'b0, e.err});
            end
            prev = bus_a.rsp_valid;
        end
    end

    // DM-side monitor: strobe exclusivity and strobe widths.
    initial begin
        int wrun_a = 0, rrun_a = 0, wrun_b = 0, rrun_b = 0;
        forever begin
            @(negedge clk);
            chk("excl_a", {31'b0, mw_a & mr_a}, 32'd0);
            chk("excl_b", {31'b0, mw_b & mr_b}, 32'd0);
            if (mw_a) wrun_a++;
            else if (wrun_a != 0) begin chk("memWrite_width_a", wrun_a, 32'd1); wrun_a = 0; end
            if (mr_a) rrun_a++;
            else if (rrun_a != 0) begin chk("memRead_width_a", rrun_a, RL_A); rrun_a = 0; end
            if (!rst_n_b) begin
                wrun_b = 0;
                rrun_b = 0;
            end else begin
                if (mw_b) wrun_b++;
                else if (wrun_b != 0) begin chk("memWrite_width_b", wrun_b, 32'd1); wrun_b = 0; end
                if (mr_b) rrun_b++;
                else if (rrun_b != 0) begin chk("memRead_width_b", rrun_b, RL_B); rrun_b = 0; end
            end
        end
    end

    // Watchdog.
    initial begin
        #(50 * 20000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, seen;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        bus_b.rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        // Reset for two cycles: only req_ready is high.
        repeat (2) @(negedge clk);
        chk("rst_ctrl_a", {bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, mw_a, mr_a}, 32'b10000);
        chk("rst_data_a", {addr_a, din_a, bus_a.rsp_rdata}, 32'd0);
        chk("rst_ctrl_b", {bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err, mw_b, mr_b}, 32'b10000);
        chk("rst_data_b", {addr_b, din_b, bus_b.rsp_rdata}, 32'd0);
        @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(negedge clk);
        chk("idle_after_rst_a", {bus_a.req_ready, bus_a.rsp_valid}, 32'b10);
        @(posedge clk);
        #1;

        // Store FF to 0, then load it back.
        issue_a(1'b1, 5'h00, 8'hFF);
        wait_idle_a();
        chk("dm_a_0", {24'b0, dm_a[0]}, 32'hFF);
        issue_a(1'b0, 5'h00, 8'h00);
        wait_idle_a();

        // Store A5 to 1F, then load it with the response stalled for 3 cycles.
        issue_a(1'b1, 5'h1F, 8'hA5);
        wait_idle_a();
        rdy_mode = 2;
        bus_a.rsp_ready = 1'b0;
        issue_a(1'b0, 5'h1F, 8'h00);
        begin
            int n = 0;
            while (!bus_a.rsp_valid && n < 20) begin @(negedge clk); n++; end
        end
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid_a", {31'b0, bus_a.rsp_valid}, 32'd1);
            chk("stall_rdata_a", {24'b0, bus_a.rsp_rdata}, 32'hA5);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_idle_a();

        // Store with a corrupting DM, then with a clean one.
        corrupt_a = 1'b1;
        issue_a(1'b1, 5'h05, 8'h3C);
        wait_idle_a();
        corrupt_a = 1'b0;
        issue_a(1'b1, 5'h05, 8'h3C);
        wait_idle_a();
        issue_a(1'b0, 5'h05, 8'h00);
        wait_idle_a();

        // Random traffic: fill every address, then mixed loads/stores.
        rdy_mode = 1;
        for (int i = 0; i < 32; i++) issue_a(1'b1, ADDR_W'(i), DATA_W'($urandom));
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue_a(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
        end
        wait_idle_a();
        rdy_mode = 0;

        // Instance B: longer read latency.
        issue_b(1'b1, 5'h03, 8'h5A, acc);
        wait_rsp_b(seen);
        chk("latency_store_b", seen - acc, VERIFY ? RL_B + 2 : 2);
        @(posedge clk); #1;
        issue_b(1'b0, 5'h03, 8'h00, acc);
        wait_rsp_b(seen);
        chk("latency_load_b", seen - acc, RL_B + 1);
        chk("rdata_b", {24'b0, bus_b.rsp_rdata}, 32'h5A);
        @(negedge clk);
        chk("rsp_one_cycle_b", {31'b0, bus_b.rsp_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset during the second memRead cycle of a load.
        issue_b(1'b0, 5'h03, 8'h00, acc);
        @(negedge clk);
        @(negedge clk);
        chk("read_cycle2_b", {31'b0, mr_b}, 32'd1);
        #5;
        rst_n_b = 1'b0;
        #1;
        chk("read_drop_b", {30'b0, mr_b, mw_b}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n_b = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_rsp_after_rst_b", {31'b0, bus_b.rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        issue_b(1'b0, 5'h03, 8'h00, acc);
        wait_rsp_b(seen);
        chk("latency_reload_b", seen - acc, RL_B + 1);
        chk("rdata_reload_b", {24'b0, bus_b.rsp_rdata}, 32'h5A);
        @(posedge clk); #1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
